// File: rtl/uart_event_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_event_tx                                              |
// | Description : Queues game events (score, lines, game over) and sends    |
// |               each as a 4-byte framed message (HDR,TYPE,PAYLOAD,CHK)    |
// |               over txdata/txclk, paced by txready handshaking.          |
// | Revision    : 1.0  initial release                                      |
// +--------------------------------------------------------------------------+
module uart_event_tx #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] HEADER     = 8'hA5
) (
   input  logic                          hz100,
   input  logic                          reset,
   input  logic [7:0]                    score,
   input  logic                          lines_pulse,
   input  logic [2:0]                    lines_n,
   input  logic                          gameover_pulse,
   input  logic                          txready,
   output logic [7:0]                    txdata,
   output logic                          txclk,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   q_count
);

   localparam int         AW      = $clog2(FIFO_DEPTH);
   localparam int         CW      = AW + 1;
   localparam logic [1:0] T_SCORE = 2'd1;
   localparam logic [1:0] T_LINES = 2'd2;
   localparam logic [1:0] T_GOVER = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_SEND    = 3'd2,
      S_WAIT_LO = 3'd3,
      S_WAIT_HI = 3'd4
   } state_t;

   // pending stage
   logic          score_pend_q, score_pend_d;
   logic [7:0]    score_ref_q,  score_ref_d;
   logic          lines_pend_q, lines_pend_d;
   logic [7:0]    lines_acc_q,  lines_acc_d;
   logic          gover_pend_q, gover_pend_d;
   logic [7:0]    gover_val_q,  gover_val_d;
   logic [8:0]    lines_sum;

   // message queue: {type[1:0], payload[7:0]}
   logic [9:0]    mem_q [FIFO_DEPTH];
   logic [9:0]    mem_d [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop, can_push;
   logic [9:0]    push_entry, head;

   // transmitter
   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [1:0]    type_q, type_d;
   logic [7:0]    payload_q, payload_d;
   logic [7:0]    txdata_q, txdata_d;

   function automatic logic [7:0] frame_byte(input logic [1:0] i,
                                             input logic [1:0] t,
                                             input logic [7:0] p);
      case (i)
         2'd0:    frame_byte = HEADER;
         2'd1:    frame_byte = {6'b0, t};
         2'd2:    frame_byte = p;
         default: frame_byte = HEADER ^ {6'b0, t} ^ p;
      endcase
   endfunction

   assign pop      = (state_q == S_LOAD);
   // a pop in the same cycle frees the slot this push takes
   assign can_push = (count_q != CW'(FIFO_DEPTH)) || pop;
   assign head     = mem_q[rptr_q];

   // Capture events into pending flags and pick at most one to enqueue
   always_comb begin
      score_pend_d = score_pend_q;
      score_ref_d  = score_ref_q;
      lines_pend_d = lines_pend_q;
      lines_acc_d  = lines_acc_q;
      gover_pend_d = gover_pend_q;
      gover_val_d  = gover_val_q;
      push         = 1'b0;
      push_entry   = 10'd0;
      lines_sum    = {1'b0, lines_acc_q} + {6'b0, lines_n};

      if (gameover_pulse) begin
         gover_pend_d = 1'b1;
         gover_val_d  = score;
      end
      if (lines_pulse) begin
         lines_pend_d = 1'b1;
         lines_acc_d  = lines_sum[8] ? 8'hFF : lines_sum[7:0];
      end
      if (score != score_ref_q) begin
         score_pend_d = 1'b1;
      end

      if (can_push) begin
         if (gover_pend_q) begin
            push         = 1'b1;
            push_entry   = {T_GOVER, gover_val_q};
            gover_pend_d = gameover_pulse;
         end else if (lines_pend_q) begin
            push         = 1'b1;
            push_entry   = {T_LINES, lines_acc_q};
            // a pulse landing now starts the next accumulation
            lines_pend_d = lines_pulse;
            lines_acc_d  = lines_pulse ? {5'b0, lines_n} : 8'd0;
         end else if (score_pend_q) begin
            push         = 1'b1;
            push_entry   = {T_SCORE, score};
            score_pend_d = 1'b0;
            score_ref_d  = score;
         end
      end
   end

   // FIFO pointer, occupancy and storage update
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) begin
         mem_d[wptr_q] = push_entry;
         wptr_d        = wptr_q + AW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Transmit FSM next-state and datapath
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      type_d    = type_q;
      payload_d = payload_q;
      txdata_d  = txdata_q;
      case (state_q)
         S_IDLE: begin
            if ((count_q != '0) && txready) state_d = S_LOAD;
         end
         S_LOAD: begin
            type_d    = head[9:8];
            payload_d = head[7:0];
            idx_d     = 2'd0;
            txdata_d  = HEADER;
            state_d   = S_SEND;
         end
         S_SEND: begin
            state_d = S_WAIT_LO;
         end
         S_WAIT_LO: begin
            if (!txready) state_d = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (txready) begin
               if (idx_q == 2'd3) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d    = idx_q + 2'd1;
                  txdata_d = frame_byte(idx_q + 2'd1, type_q, payload_q);
                  state_d  = S_SEND;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge hz100) begin
      if (reset) begin
         score_pend_q <= 1'b0;
         score_ref_q  <= 8'd0;
         lines_pend_q <= 1'b0;
         lines_acc_q  <= 8'd0;
         gover_pend_q <= 1'b0;
         gover_val_q  <= 8'd0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 10'd0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         state_q      <= S_IDLE;
         idx_q        <= 2'd0;
         type_q       <= 2'd0;
         payload_q    <= 8'd0;
         txdata_q     <= 8'd0;
      end else begin
         score_pend_q <= score_pend_d;
         score_ref_q  <= score_ref_d;
         lines_pend_q <= lines_pend_d;
         lines_acc_q  <= lines_acc_d;
         gover_pend_q <= gover_pend_d;
         gover_val_q  <= gover_val_d;
         mem_q        <= mem_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         type_q       <= type_d;
         payload_q    <= payload_d;
         txdata_q     <= txdata_d;
      end
   end

   assign txdata  = txdata_q;
   assign txclk   = (state_q == S_SEND);
   assign busy    = (state_q != S_IDLE);
   assign q_count = count_q;

endmodule
`default_nettype wire

// File: doc/uart_event_tx.md
# uart_event_tx

Outbound side of the board's UART port pair. Queues game events (score change, lines cleared, game over) and serialises each one as a 4-byte framed message onto `txdata`/`txclk`, paced by the host-side `txready` flow control. It sits beside the tetris FSM and score logic in `top`, drives the `txdata`/`txclk` outputs, and is the transmit counterpart to the `rxdata`/`rxready` receive path.

## Interface
- `FIFO_DEPTH`, 4: message queue entries; power of two, minimum 2.
- `HEADER`, 8'hA5: first byte of every frame.
- `hz100`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `score`  in  8  current game score, level signal.
- `lines_pulse`  in  1  one-cycle strobe: `lines_n` rows were cleared this cycle.
- `lines_n`  in  3  rows cleared (1–4); valid only with `lines_pulse`.
- `gameover_pulse`  in  1  one-cycle strobe: game ended.
- `txready`  in  1  host UART can accept a byte (1 = ready).
- `txdata`  out  8  byte being offered.
- `txclk`  out  1  one-cycle write strobe for `txdata`.
- `busy`  out  1  a frame is in flight (state ≠ IDLE).
- `q_count`  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

## Operation
- **Frame format:** `HEADER`, TYPE, PAYLOAD, CHK, where CHK = `HEADER` ^ TYPE ^ PAYLOAD.
  - SCORE: TYPE 8'h01, payload = score.
  - LINES: TYPE 8'h02, payload = accumulated lines.
  - GAMEOVER: TYPE 8'h03, payload = score sampled at the pulse.
- **Pending stage:** three pending flags with payload registers.
  - `score_pend` is set whenever `score` ≠ `score_ref`.
  - `lines_pulse` sets `lines_pend` and adds `lines_n` to `lines_acc`, saturating at 255. Pulses arriving while the flag is already set accumulate.
  - `gameover_pulse` sets `gover_pend` and latches `score`. A repeat pulse while pending overwrites the latched value.
- **Enqueue:** at most one FIFO write per cycle, only when the FIFO is not full. Priority is GAMEOVER > LINES > SCORE.
  - Enqueuing clears the corresponding flag.
  - For LINES, `lines_acc` is reset to 0, or to `lines_n` if a new pulse lands in the same cycle.
  - For SCORE, the current `score` is enqueued and `score_ref <= score`.
  - When the FIFO is full, flags persist; events are not lost, only coalesced.
- **FIFO:** entries are {type[1:0], payload[7:0]}. Read and write may occur in the same cycle, including when full (pop frees the slot that push takes).
- **TX FSM states:**
  - IDLE: if FIFO non-empty and `txready`=1, go to LOAD.
  - LOAD: pop the FIFO, latch type/payload, set `idx`=0, go to SEND.
  - SEND: `txdata` = byte[idx], `txclk`=1 for exactly this cycle, go to WAIT_LO.
  - WAIT_LO: hold until `txready`=0, then go to WAIT_HI.
  - WAIT_HI: hold until `txready`=1. If `idx`=3, go to IDLE; else increment `idx` and go to SEND.
- `txdata` holds the last sent byte outside SEND. It is 8'h00 after reset.

## Timing
- **Reset** (sampled on `hz100` posedge while `reset`=1):
  - State ← IDLE; `txclk`=0, `txdata`=0, `busy`=0, `q_count`=0.
  - FIFO emptied; all pending flags cleared; `score_ref`=0; `lines_acc`=0.
  - Reset mid-frame aborts the frame with no further strobes; partial frames are never resumed.
- **Latency**, with FIFO empty, FSM IDLE and `txready`=1: for an event sampled at edge N, pending is set at N+1 and enqueued at N+2. LOAD occupies cycle N+3. First `txclk` is high during cycle N+4.
- **Strobes:** successive `txclk` strobes are separated by at least 2 cycles (WAIT_LO and WAIT_HI are each at least one cycle). `txclk` never asserts on consecutive cycles.
- **`txready` inputs:**
  - `txready` low in IDLE stalls frame start.
  - `txready` stuck high after a strobe stalls in WAIT_LO indefinitely; this is by design.
- **Inputs:** `lines_n` of 0 or greater than 4 is added as given; range checking is the producer's job.

## Test plan
- **Reset then score:** reset, then `score` 0→8'h12 with the host answering each strobe with `txready` low 1 cycle then high. Expect bytes A5, 01, 12, B6; first `txclk` 4 cycles after the change; `busy` returns 0.
- **Simultaneous events:** `gameover_pulse`, `lines_pulse` with `lines_n`=2, and `score`→8'h05 all in one cycle. Expect frames in order GAMEOVER (payload 05, CHK A3), LINES (02, CHK A5), SCORE (05, CHK A1).
- **Coalescing:** hold `txready`=0 and issue 6 lines pulses of 4 with FIFO_DEPTH=4. Expect `q_count` to saturate at 4 and nothing lost. On release, expect frames whose LINES payloads sum to 24.
- **Saturation:** 70 lines pulses of 4 while blocked. Expect the accumulated LINES payload to clamp at 8'hFF.
- **Reset mid-frame:** assert `reset` after the 2nd byte strobe. Expect no further `txclk`, `q_count`=0, `busy`=0 next cycle. A new score change afterwards produces a full 4-byte frame.
- **Stalled host:** keep `txready` high after a strobe. Expect the FSM parked in WAIT_LO with no duplicate strobe; dropping then raising `txready` resumes with the next byte.
